// File: rtl/led_chaser_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_chaser_pwm
// Purpose  : Two-group LED chaser with per-LED PWM brightness and optional
//            fading trail (enable with macro LED_CHASER_TRAIL_EN).
// Revision : 1.0  initial release
// ============================================================================
module led_chaser_pwm #(
  parameter int NUM_LEDS = 11,
  parameter int SPLIT    = 6,
  parameter int DIV      = 2000000,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [NUM_LEDS-1:0] ledc
);

  localparam int PW = $clog2(NUM_LEDS) + 1;
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [1:0] c_mode_fwd  = 2'b00;
  localparam logic [1:0] c_mode_rev  = 2'b01;
  localparam logic [1:0] c_mode_bnc  = 2'b10;
  localparam logic [1:0] c_mode_hold = 2'b11;

  localparam logic [PW-1:0] c_one     = PW'(1);
  localparam logic [PW-1:0] c_a_first = '0;
  localparam logic [PW-1:0] c_a_last  = PW'(SPLIT - 1);
  localparam logic [PW-1:0] c_b_first = PW'(SPLIT);
  localparam logic [PW-1:0] c_b_last  = PW'(NUM_LEDS - 1);
  localparam logic [DW-1:0] c_div_max = DW'(DIV - 1);

  logic [DW-1:0]                     div_q, div_d;
  logic [PWM_BITS-1:0]               pwm_q, pwm_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] bright_q, bright_d;
  logic [PW-1:0]                     pos_a_q, pos_a_d, pos_b_q, pos_b_d;
  logic                              dir_a_q, dir_a_d, dir_b_q, dir_b_d;
  logic [NUM_LEDS-1:0]               ledc_q, ledc_d;
  logic                              w_tick;

  // Returns {next_dir, next_pos}; dir 1 = up. A one-LED group never moves.
  function automatic logic [PW:0] step(input logic [PW-1:0] pos, input logic dir,
                                       input logic [1:0] md,
                                       input logic [PW-1:0] first, input logic [PW-1:0] last);
    logic [PW-1:0] np;
    logic          nd;
    np = pos;
    nd = dir;
    if (first != last) begin
      case (md)
        c_mode_fwd: begin
          nd = 1'b1;
          np = (pos == last) ? first : pos + c_one;
        end
        c_mode_rev: begin
          nd = 1'b0;
          np = (pos == first) ? last : pos - c_one;
        end
        c_mode_bnc: begin
          if (dir) begin
            if (pos == last) begin
              nd = 1'b0;
              np = pos - c_one;
            end else begin
              np = pos + c_one;
            end
          end else begin
            if (pos == first) begin
              nd = 1'b1;
              np = pos + c_one;
            end else begin
              np = pos - c_one;
            end
          end
        end
        default: ;
      endcase
    end
    return {nd, np};
  endfunction

  function automatic logic [PWM_BITS-1:0] trail(input logic [PWM_BITS-1:0] b);
`ifdef LED_CHASER_TRAIL_EN
    return b >> 1;
`else
    return '0;
`endif
  endfunction

  assign w_tick = enable && (div_q == c_div_max);

  always_comb begin
    div_d = div_q;
    if (enable) begin
      div_d = (div_q == c_div_max) ? '0 : div_q + DW'(1);
    end
    pwm_d = pwm_q + PWM_BITS'(1);
  end

  always_comb begin
    bright_d = bright_q;
    pos_a_d  = pos_a_q;
    pos_b_d  = pos_b_q;
    dir_a_d  = dir_a_q;
    dir_b_d  = dir_b_q;
    if (w_tick && (mode != c_mode_hold)) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (i < SPLIT) begin
          bright_d[i] = (PW'(i) == pos_a_q) ? brightness : trail(bright_q[i]);
        end else begin
          bright_d[i] = (PW'(i) == pos_b_q) ? brightness : trail(bright_q[i]);
        end
      end
      {dir_a_d, pos_a_d} = step(pos_a_q, dir_a_q, mode, c_a_first, c_a_last);
      {dir_b_d, pos_b_d} = step(pos_b_q, dir_b_q, mode, c_b_first, c_b_last);
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ledc
    assign ledc_d[gi] = (bright_q[gi] > pwm_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      pwm_q    <= '0;
      bright_q <= '0;
      pos_a_q  <= c_a_first;
      pos_b_q  <= c_b_first;
      dir_a_q  <= 1'b1;
      dir_b_q  <= 1'b1;
      ledc_q   <= '0;
    end else begin
      div_q    <= div_d;
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
      pos_a_q  <= pos_a_d;
      pos_b_q  <= pos_b_d;
      dir_a_q  <= dir_a_d;
      dir_b_q  <= dir_b_d;
      ledc_q   <= ledc_d;
    end
  end

  assign ledc = ledc_q;

endmodule
`default_nettype wire

// File: tb/tb_led_chaser_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_chaser_pwm
// Purpose  : Scoreboard bench for led_chaser_pwm with hand-computed vectors.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_chaser_pwm;

  localparam int NL = 11;
  localparam int SP = 6;
  localparam int DV = 4;
  localparam int PB = 4;

  // Nibble i of each vector is the expected brightness of LED i.
`ifdef LED_CHASER_TRAIL_EN
  localparam logic [43:0] E_F3 = 44'h00F73000F73;
  localparam logic [43:0] E_F6 = 44'h7310FF73100;
  localparam logic [43:0] E_F7 = 44'h310F773100F;
  localparam logic [43:0] E_B6 = 44'h7F100F73100;
  localparam logic [43:0] E_R2 = 44'hF0007F00007;
  localparam logic [43:0] E_EN = 44'h000F70000F7;
`else
  localparam logic [43:0] E_F3 = 44'h00F00000F00;
  localparam logic [43:0] E_F6 = 44'h0000FF00000;
  localparam logic [43:0] E_F7 = 44'h000F000000F;
  localparam logic [43:0] E_B6 = 44'h0F000F00000;
  localparam logic [43:0] E_R2 = 44'hF0000F00000;
  localparam logic [43:0] E_EN = 44'h000F00000F0;
`endif
  localparam logic [43:0] E_R1 = 44'h00009000009;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [PB-1:0] brightness = '0;
  logic [NL-1:0] ledc;

  always #5 clk = ~clk;

  led_chaser_pwm #(.NUM_LEDS(NL), .SPLIT(SP), .DIV(DV), .PWM_BITS(PB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .brightness(brightness), .ledc(ledc)
  );

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       name;
  } item_t;

  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    meas0   = 0;
  int    meas1   = 0;

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      0:       return 64'(dut.bright_q);
      1:       return 64'(ledc);
      2:       return 64'({dut.pos_a_q, dut.pos_b_q});
      3:       return 64'(meas0);
      4:       return 64'(dut.pwm_q);
      5:       return 64'(dut.div_q);
      default: return 64'(meas1);
    endcase
  endfunction

  function automatic logic [63:0] pp(input int a, input int b);
    logic [4:0] pa, pb;
    pa = 5'(a);
    pb = 5'(b);
    return 64'({pa, pb});
  endfunction

  // Monitor: drains expectations as the DUT state becomes observable.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      item_t       it;
      logic [63:0] a;
      it = exp_q.pop_front();
      a  = actual(it.sel);
      n_tests++;
      if (a !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", it.name, a, it.exp);
      end
    end
  end

  task automatic chk(input int sel, input logic [63:0] e, input string nm);
    item_t it;
    it.sel  = sel;
    it.exp  = e;
    it.name = nm;
    exp_q.push_back(it);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n * DV) @(posedge clk);
    #1;
  endtask

  task automatic duty(input int i0, input int i1);
    int c0, c1;
    c0 = 0;
    c1 = 0;
    repeat (16) begin
      @(negedge clk);
      c0 += int'(ledc[i0]);
      c1 += int'(ledc[i1]);
    end
    meas0 = c0;
    meas1 = c1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset mid-run, then first tick lands on the fourth edge after release
    brightness = 4'd9;
    do_reset();
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk(0, 64'd0, "reset_bright");
    chk(1, 64'd0, "reset_ledc");
    chk(2, pp(0, 6), "reset_pos");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(0, 64'd0, "pre_first_tick");
    @(posedge clk);
    #1;
    chk(0, 64'(E_R1), "first_tick");

    // Forward
    brightness = 4'd15;
    mode = 2'b00;
    do_reset();
    ticks(3);
    chk(0, 64'(E_F3), "fwd_t3_bright");
    ticks(3);
    chk(0, 64'(E_F6), "fwd_t6_bright");
    chk(2, pp(0, 7), "fwd_t6_pos");
    ticks(1);
    chk(0, 64'(E_F7), "fwd_t7_bright");
    chk(2, pp(1, 8), "fwd_t7_pos");

    // Bounce
    mode = 2'b10;
    do_reset();
    ticks(5);
    chk(2, pp(5, 9), "bnc_t5_pos");
    ticks(1);
    chk(0, 64'(E_B6), "bnc_t6_bright");
    chk(2, pp(4, 8), "bnc_t6_pos");
    ticks(5);
    chk(2, pp(1, 9), "bnc_t11_pos");

    // Reverse, then bounce resumes downward
    mode = 2'b01;
    do_reset();
    ticks(2);
    chk(0, 64'(E_R2), "rev_t2_bright");
    chk(2, pp(4, 9), "rev_t2_pos");
    mode = 2'b10;
    ticks(1);
    chk(2, pp(3, 8), "rev_bnc_pos");

    // PWM duty with held brightness
    brightness = 4'd8;
    mode = 2'b00;
    do_reset();
    ticks(1);
    mode = 2'b11;
    repeat (3) @(posedge clk);
    duty(0, 1);
    chk(3, 64'd8, "duty_8");
    chk(6, 64'd0, "duty_0");
    brightness = 4'd15;
    mode = 2'b00;
    do_reset();
    ticks(1);
    mode = 2'b11;
    repeat (3) @(posedge clk);
    duty(0, 6);
    chk(3, 64'd15, "duty_15_a");
    chk(6, 64'd15, "duty_15_b");

    // Enable freeze, then hold mode
    mode = 2'b00;
    do_reset();
    ticks(2);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk(0, 64'(E_EN), "dis_bright");
    chk(2, pp(2, 8), "dis_pos");
    chk(5, 64'd1, "dis_div");
    chk(4, 64'd13, "dis_pwm");
    enable = 1'b1;
    mode = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    chk(0, 64'(E_EN), "hold_bright");
    chk(2, pp(2, 8), "hold_pos");
    chk(5, 64'd1, "hold_div");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    if (n_tests < 12) begin
      n_fail++;
      $display("FAIL count: got %0d tests expected at least 12", n_tests);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL");
    end
    $finish;
  end

endmodule
`default_nettype wire
